// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq : parametrised board-level reset sequencer
//
// Waits for a debounced PLL lock. Holds every reset domain asserted for a fixed
// time, then releases the domains one by one with a fixed stagger. In the run
// state a software request or a PLL lock loss re-asserts all domains
// synchronously and starts the sequence again.
//
// Optional feature (compile-time macro RST_SEQ_WDT_EN):
//   Adds parameter WDT_CYCLES and a run-state watchdog. If no kick arrives in
//   time, the watchdog triggers a software-style reset and sets the sticky
//   wdt_fired flag. Without the macro, wdt_kick is ignored and wdt_fired is 0.
//
// Ports:
//   clk              in   system clock (PLL output)
//   rst_n            in   asynchronous active-low reset
//   pll_locked       in   raw PLL lock, asynchronous to clk
//   sw_rst_req       in   single-cycle software reset request (honoured in RUN)
//   clr_sticky       in   synchronous clear of lock_lost_sticky
//   wdt_kick         in   watchdog kick
//   rst_out_n        out  per-domain active-low resets, bit 0 released first
//   all_released     out  high only while every domain is released (RUN)
//   lock_lost_sticky out  set when an accepted lock is lost
//   wdt_fired        out  sticky watchdog-timeout flag
// -----------------------------------------------------------------------------
module rst_seq #(
   parameter int NUM_DOMAINS    = 3,
   parameter int LOCK_FILTER    = 4,
   parameter int HOLD_CYCLES    = 8,
   parameter int STAGGER_CYCLES = 4,
   parameter int SW_RST_CYCLES  = 16
`ifdef RST_SEQ_WDT_EN
   ,
   parameter int WDT_CYCLES     = 1024
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pll_locked,
   input  logic                   sw_rst_req,
   input  logic                   clr_sticky,
   input  logic                   wdt_kick,
   output logic [NUM_DOMAINS-1:0] rst_out_n,
   output logic                   all_released,
   output logic                   lock_lost_sticky,
   output logic                   wdt_fired
);

   localparam int FILT_W = $clog2(LOCK_FILTER + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int STG_W  = $clog2(STAGGER_CYCLES + 1);
   localparam int SW_W   = $clog2(SW_RST_CYCLES + 1);

   typedef enum logic [2:0] {
      S_WAIT_LOCK,
      S_HOLD,
      S_RELEASE,
      S_RUN,
      S_SW_RESET
   } state_t;

   state_t                 r_state, w_state_next;
   logic                   r_sync1, r_lock_s;
   logic [FILT_W-1:0]      r_filt, w_filt_next;
   logic [HOLD_W-1:0]      r_hold, w_hold_next;
   logic [STG_W-1:0]       r_stg, w_stg_next;
   logic [SW_W-1:0]        r_sw, w_sw_next;
   logic [NUM_DOMAINS-1:0] r_rst_out_n, w_rst_out_n_next;
   logic                   r_all_released, w_all_released_next;
   logic                   r_sticky, w_sticky_next;
   logic                   w_lock_loss;
   logic                   w_wdt_timeout;
   logic                   w_wdt_hit;

   // Lock is only "lost" once it has been accepted; glitches while filtering
   // just restart the filter.
   assign w_lock_loss = (r_state != S_WAIT_LOCK) && !r_lock_s;

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next        = r_state;
      w_filt_next         = r_filt;
      w_hold_next         = '0;
      w_stg_next          = '0;
      w_sw_next           = '0;
      w_rst_out_n_next    = r_rst_out_n;
      w_all_released_next = r_all_released;
      w_sticky_next       = r_sticky & ~clr_sticky;
      w_wdt_hit           = 1'b0;

      if (w_lock_loss) begin
         // Lock loss outranks every other request; the set beats clr_sticky.
         w_state_next        = S_WAIT_LOCK;
         w_filt_next         = '0;
         w_rst_out_n_next    = '0;
         w_all_released_next = 1'b0;
         w_sticky_next       = 1'b1;
      end else begin
         case (r_state)
            S_WAIT_LOCK: begin
               w_rst_out_n_next    = '0;
               w_all_released_next = 1'b0;
               if (!r_lock_s) begin
                  w_filt_next = '0;
               end else if (r_filt >= FILT_W'(LOCK_FILTER - 1)) begin
                  w_filt_next  = '0;
                  w_state_next = S_HOLD;
               end else begin
                  w_filt_next = r_filt + 1'b1;
               end
            end

            S_HOLD: begin
               w_rst_out_n_next = '0;
               if (r_hold >= HOLD_W'(HOLD_CYCLES - 1)) begin
                  // Domain 0 is released on the edge that leaves HOLD; with a
                  // single domain this is also the last one.
                  w_rst_out_n_next = NUM_DOMAINS'(1);
                  if (w_rst_out_n_next[NUM_DOMAINS-1]) begin
                     w_state_next        = S_RUN;
                     w_all_released_next = 1'b1;
                  end else begin
                     w_state_next = S_RELEASE;
                  end
               end else begin
                  w_hold_next = r_hold + 1'b1;
               end
            end

            S_RELEASE: begin
               if (r_stg >= STG_W'(STAGGER_CYCLES - 1)) begin
                  // Released bits form a contiguous run from bit 0, so shifting
                  // in a 1 releases exactly the next domain.
                  w_rst_out_n_next = (r_rst_out_n << 1) | NUM_DOMAINS'(1);
                  if (w_rst_out_n_next[NUM_DOMAINS-1]) begin
                     w_state_next        = S_RUN;
                     w_all_released_next = 1'b1;
                  end
               end else begin
                  w_stg_next = r_stg + 1'b1;
               end
            end

            S_RUN: begin
               if (sw_rst_req || w_wdt_timeout) begin
                  w_state_next        = S_SW_RESET;
                  w_rst_out_n_next    = '0;
                  w_all_released_next = 1'b0;
                  // A watchdog timeout counts as fired only when it is the
                  // actual cause of the reset.
                  w_wdt_hit           = !sw_rst_req;
               end
            end

            S_SW_RESET: begin
               w_rst_out_n_next    = '0;
               w_all_released_next = 1'b0;
               if (r_sw >= SW_W'(SW_RST_CYCLES - 1)) begin
                  // Lock is still good here, so skip the filter.
                  w_state_next = S_HOLD;
               end else begin
                  w_sw_next = r_sw + 1'b1;
               end
            end

            default: begin
               w_state_next        = S_WAIT_LOCK;
               w_filt_next         = '0;
               w_rst_out_n_next    = '0;
               w_all_released_next = 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State, counters, synchroniser and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1        <= 1'b0;
         r_lock_s       <= 1'b0;
         r_state        <= S_WAIT_LOCK;
         r_filt         <= '0;
         r_hold         <= '0;
         r_stg          <= '0;
         r_sw           <= '0;
         r_rst_out_n    <= '0;
         r_all_released <= 1'b0;
         r_sticky       <= 1'b0;
      end else begin
         r_sync1        <= pll_locked;
         r_lock_s       <= r_sync1;
         r_state        <= w_state_next;
         r_filt         <= w_filt_next;
         r_hold         <= w_hold_next;
         r_stg          <= w_stg_next;
         r_sw           <= w_sw_next;
         r_rst_out_n    <= w_rst_out_n_next;
         r_all_released <= w_all_released_next;
         r_sticky       <= w_sticky_next;
      end
   end

   assign rst_out_n        = r_rst_out_n;
   assign all_released     = r_all_released;
   assign lock_lost_sticky = r_sticky;

   // -------------------------------------------------------------------------
   // Optional run-state watchdog
   // -------------------------------------------------------------------------
`ifdef RST_SEQ_WDT_EN
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);

   logic [WDT_W-1:0] r_wdt;
   logic             r_wdt_fired;

   assign w_wdt_timeout = (r_state == S_RUN) && !wdt_kick &&
                          (r_wdt >= WDT_W'(WDT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdt       <= '0;
         r_wdt_fired <= 1'b0;
      end else begin
         // Count only while staying in RUN; any exit or entry restarts at 0.
         if ((r_state == S_RUN) && (w_state_next == S_RUN)) begin
            if (wdt_kick) begin
               r_wdt <= '0;
            end else if (r_wdt < WDT_W'(WDT_CYCLES - 1)) begin
               r_wdt <= r_wdt + 1'b1;
            end
         end else begin
            r_wdt <= '0;
         end
         if (w_wdt_hit) begin
            r_wdt_fired <= 1'b1;
         end
      end
   end

   assign wdt_fired = r_wdt_fired;
`else
   logic w_unused_wdt;

   assign w_wdt_timeout = 1'b0;
   assign w_unused_wdt  = wdt_kick ^ w_wdt_hit;
   assign wdt_fired     = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_rst_seq : self-checking bench for rst_seq
//
// A timeline model tracks "edges since hold started" and "edges since the
// software reset started". Expected outputs are derived arithmetically from
// those counts. A compare process checks the DUT against the model on every
// negative clock edge. Directed phases add literal expectations for the
// documented timing points. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_rst_seq;

   localparam int N        = 3;
   localparam int LF       = 4;
   localparam int HC       = 8;
   localparam int SC       = 4;
   localparam int SWC      = 16;
   localparam int REL_LAST = HC + (N - 1) * SC;
   localparam int CAP      = 1 << 20;
`ifdef RST_SEQ_WDT_EN
   localparam int WDT      = 32;
`endif

   logic         clk        = 1'b0;
   logic         rst_n      = 1'b0;
   logic         pll_locked = 1'b0;
   logic         sw_rst_req = 1'b0;
   logic         clr_sticky = 1'b0;
   logic         wdt_kick   = 1'b0;
   logic [N-1:0] rst_out_n;
   logic         all_released;
   logic         lock_lost_sticky;
   logic         wdt_fired;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   // model state
   bit m_sh1, m_sh2, m_acc, m_in_sw, m_sticky, m_fired;
   int m_run, m_e, m_swe, m_wd;

   int pa_edge [6] = '{13, 14, 17, 18, 21, 22};
   int pa_rst  [6] = '{0, 1, 1, 3, 3, 7};
   int pa_all  [6] = '{0, 0, 0, 0, 0, 1};

   always #5 clk = ~clk;

   rst_seq #(
      .NUM_DOMAINS    (N),
      .LOCK_FILTER    (LF),
      .HOLD_CYCLES    (HC),
      .STAGGER_CYCLES (SC),
      .SW_RST_CYCLES  (SWC)
`ifdef RST_SEQ_WDT_EN
      ,
      .WDT_CYCLES     (WDT)
`endif
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pll_locked       (pll_locked),
      .sw_rst_req       (sw_rst_req),
      .clr_sticky       (clr_sticky),
      .wdt_kick         (wdt_kick),
      .rst_out_n        (rst_out_n),
      .all_released     (all_released),
      .lock_lost_sticky (lock_lost_sticky),
      .wdt_fired        (wdt_fired)
   );

   // ---------------------------------------------------------------- model
   task automatic model_reset();
      m_sh1 = 0; m_sh2 = 0; m_acc = 0; m_in_sw = 0; m_sticky = 0; m_fired = 0;
      m_run = 0; m_e = 0; m_swe = 0; m_wd = 0;
   endtask

   task automatic model_step();
      bit ls, loss, running, keep_wd;
      ls = m_sh2;
      loss = 0;
      keep_wd = 0;
      running = 0;
      if (!m_acc) begin
         if (ls) begin
            m_run++;
            if (m_run >= LF) begin
               m_acc = 1; m_in_sw = 0; m_e = 0; m_run = 0;
            end
         end else begin
            m_run = 0;
         end
      end else if (!ls) begin
         loss = 1; m_acc = 0; m_in_sw = 0; m_run = 0;
      end else if (m_in_sw) begin
         m_swe++;
         if (m_swe >= SWC) begin
            m_in_sw = 0; m_e = 0;
         end
      end else begin
         running = (m_e >= REL_LAST);
         if (running && sw_rst_req) begin
            m_in_sw = 1; m_swe = 0;
         end
`ifdef RST_SEQ_WDT_EN
         else if (running && !wdt_kick && m_wd == WDT - 1) begin
            m_in_sw = 1; m_swe = 0; m_fired = 1;
         end
`endif
         else begin
            if (running) begin
               keep_wd = 1;
               m_wd = wdt_kick ? 0 : m_wd + 1;
            end
            if (m_e < CAP) m_e++;
         end
      end
      if (!keep_wd) m_wd = 0;
      m_sticky = loss || (m_sticky && !clr_sticky);
      m_sh2 = m_sh1;
      m_sh1 = pll_locked;
   endtask

   function automatic logic [N-1:0] model_rst();
      logic [N-1:0] v;
      v = '0;
      if (m_acc && !m_in_sw)
         for (int i = 0; i < N; i++) v[i] = (m_e >= HC + i * SC);
      return v;
   endfunction

   function automatic logic model_all();
      return m_acc && !m_in_sw && (m_e >= REL_LAST);
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // ---------------------------------------------------------------- checks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("cyc_rst_out_n", 32'(rst_out_n), 32'(model_rst()));
            check("cyc_flags", {29'd0, all_released, lock_lost_sticky, wdt_fired},
                  {29'd0, model_all(), m_sticky, m_fired});
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 0; pll_locked = 0; sw_rst_req = 0; clr_sticky = 0;
      tick();
      cmp_en = 1;
      tick();
      check("rst_state_out", 32'(rst_out_n), 0);
      check("rst_state_all", 32'(all_released), 0);
      check("rst_state_sticky", 32'(lock_lost_sticky), 0);
      check("rst_state_wdt", 32'(wdt_fired), 0);
      rst_n = 1;
   endtask

   task automatic wait_run();
      int n;
      n = 0;
      while (all_released !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (all_released !== 1'b1) begin
         errors++;
         $display("FAIL wait_run: all_released=%b after %0d cycles, expected 1", all_released, n);
      end
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      bit glitch;
      int r;
      glitch = 0;
`ifdef RST_SEQ_WDT_EN
      wdt_kick = 1;
`endif
      // Power-up: lock present before edge 1
      do_reset();
      pll_locked = 1;
      for (int k = 1; k <= 22; k++) begin
         tick();
         for (int q = 0; q < 6; q++) begin
            if (pa_edge[q] == k) begin
               check($sformatf("pwr_rst_e%0d", k), 32'(rst_out_n), pa_rst[q]);
               check($sformatf("pwr_all_e%0d", k), 32'(all_released), pa_all[q]);
               check($sformatf("pwr_model_e%0d", k), 32'(model_rst()), pa_rst[q]);
            end
         end
      end

      // Lock glitch: high for edges 1..3, low at edge 4, high again from 5
      do_reset();
      pll_locked = 1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 3) pll_locked = 0;
         if (k == 4) pll_locked = 1;
         if (k == 17) check("glitch_rst_e17", 32'(rst_out_n), 0);
         if (k == 18) check("glitch_rst_e18", 32'(rst_out_n), 1);
      end
      check("glitch_sticky", 32'(lock_lost_sticky), 0);
      wait_run();

      // Lock loss in RUN
      pll_locked = 0;
      tick();
      tick();
      check("loss_rst_still_up", 32'(rst_out_n), 7);
      tick();
      check("loss_rst_down", 32'(rst_out_n), 0);
      check("loss_sticky", 32'(lock_lost_sticky), 1);
      repeat (3) tick();
      pll_locked = 1;
      wait_run();
      check("loss_sticky_kept", 32'(lock_lost_sticky), 1);
      clr_sticky = 1;
      tick();
      clr_sticky = 0;
      check("loss_sticky_clr", 32'(lock_lost_sticky), 0);

      // Software reset in RUN, plus an ignored request during RELEASE
      sw_rst_req = 1;
      tick();
      sw_rst_req = 0;
      check("sw_rst_down", 32'(rst_out_n), 0);
      check("sw_all_down", 32'(all_released), 0);
      for (int j = 1; j <= 32; j++) begin
         sw_rst_req = (j == 26);
         tick();
         if (j == 23) check("sw_rst_j23", 32'(rst_out_n), 0);
         if (j == 24) check("sw_rst_j24", 32'(rst_out_n), 1);
         if (j == 28) check("sw_rst_j28", 32'(rst_out_n), 3);
         if (j == 31) check("sw_all_j31", 32'(all_released), 0);
         if (j == 32) begin
            check("sw_rst_j32", 32'(rst_out_n), 7);
            check("sw_all_j32", 32'(all_released), 1);
         end
      end
      sw_rst_req = 0;

      // Simultaneous lock loss and software request
      pll_locked = 0;
      tick();
      tick();
      sw_rst_req = 1;
      tick();
      sw_rst_req = 0;
      pll_locked = 1;
      check("both_rst", 32'(rst_out_n), 0);
      check("both_sticky", 32'(lock_lost_sticky), 1);
      for (int j = 1; j <= 14; j++) begin
         tick();
         if (j == 13) check("both_rst_j13", 32'(rst_out_n), 0);
         if (j == 14) check("both_rst_j14", 32'(rst_out_n), 1);
      end
      wait_run();

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         r = int'($urandom_range(0, 999));
         if (glitch) begin
            pll_locked = 1;
            glitch = 0;
         end else if (pll_locked && r < 4) begin
            pll_locked = 0;
         end else if (pll_locked && r < 7) begin
            pll_locked = 0;
            glitch = 1;
         end else if (!pll_locked && r < 20) begin
            pll_locked = 1;
         end
         sw_rst_req = ($urandom_range(0, 59) == 0);
         clr_sticky = ($urandom_range(0, 99) == 0);
         wdt_kick   = ($urandom_range(0, 39) == 0);
         rst_n      = ($urandom_range(0, 1499) != 0);
         tick();
      end
      rst_n = 1;
      sw_rst_req = 0;
      clr_sticky = 0;

`ifdef RST_SEQ_WDT_EN
      // Watchdog: no kick -> reset 32 edges after RUN entry
      wdt_kick = 0;
      do_reset();
      pll_locked = 1;
      wait_run();
      for (int j = 1; j <= 32; j++) begin
         tick();
         if (j == 31) begin
            check("wdt_up_j31", 32'(rst_out_n), 7);
            check("wdt_fired_j31", 32'(wdt_fired), 0);
         end
         if (j == 32) begin
            check("wdt_rst_j32", 32'(rst_out_n), 0);
            check("wdt_fired_j32", 32'(wdt_fired), 1);
         end
      end
      // Kick every 20 cycles -> stays in RUN
      do_reset();
      pll_locked = 1;
      wait_run();
      for (int j = 1; j <= 100; j++) begin
         wdt_kick = (j % 20 == 0);
         tick();
         check("wdt_kick_run", 32'(all_released), 1);
      end
      check("wdt_kick_fired", 32'(wdt_fired), 0);
      wdt_kick = 0;
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
